// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Transmit engine of the UART: pops bytes from the TX FIFO head and
//   serializes each one as start bit, 5..8 data bits LSB first, optional
//   parity and 1 / 1.5 / 2 stop bits.  Every bit lasts OVERSAMPLE baud_pulse
//   ticks.  Also provides the break function and transmitter-empty status.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset (0 = reset)
//   baud_pulse  one-clk oversample tick from the baud generator
//   wls         word length select: 00=5, 01=6, 10=7, 11=8 bits
//   stb         0 = 1 stop bit, 1 = 2 stop bits (1.5 when wls=00)
//   pen         parity enable
//   eps         1 = even parity, 0 = odd parity
//   sp          stick parity (parity bit = ~eps when pen=1)
//   bc          break control, forces tx low while high
//   fifo_empty  TX FIFO empty flag
//   fifo_dout   TX FIFO head byte
//   pop         FIFO pop strobe, one clk wide
//   tx          serial output, idle high
//   busy        frame in progress
//   temt        transmitter idle and FIFO empty
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       pop,
  output logic       tx,
  output logic       busy,
  output logic       temt
);

  // Counter must hold up to 2*OVERSAMPLE-1 (two stop bits).
  localparam int CW = $clog2(2 * OVERSAMPLE);

  localparam logic [CW-1:0] BIT_LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP15_LAST = CW'((OVERSAMPLE * 3) / 2 - 1);
  localparam logic [CW-1:0] STOP2_LAST  = CW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [1:0]    cfg_wls;
  logic          cfg_stb;
  logic          cfg_pen;
  logic          cfg_par;   // parity bit resolved at load time
  logic          line;      // registered line value before break gating

  logic [CW-1:0] stop_last;
  logic [2:0]    data_last;
  logic [7:0]    data_mask;
  logic          data_xor;
  logic          par_bit;
  logic          stop_end;
  logic          load;

  // Stop length depends on the latched frame configuration.
  always_comb begin
    stop_last = BIT_LAST;
    if (cfg_stb) begin
      stop_last = (cfg_wls == 2'b00) ? STOP15_LAST : STOP2_LAST;
    end
  end

  // Index of the last data bit of the current frame (N-1).
  assign data_last = {1'b0, cfg_wls} + 3'd4;

  // Parity covers only the N transmitted bits, so mask the head byte with
  // the live word length before folding it.
  assign data_mask = 8'hFF >> (2'd3 - wls);
  assign data_xor  = ^(fifo_dout & data_mask);
  assign par_bit   = sp ? ~eps : (eps ? data_xor : ~data_xor);

  assign stop_end = baud_pulse && (state == STOP) && (tick_cnt == stop_last);

  // Reload on the final stop tick gives back-to-back frames with no idle gap.
  // Gated by rst so no pop can escape while the block is held in reset.
  assign load = rst && baud_pulse && !fifo_empty && ((state == IDLE) || stop_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      cfg_wls  <= '0;
      cfg_stb  <= 1'b0;
      cfg_pen  <= 1'b0;
      cfg_par  <= 1'b0;
      line     <= 1'b1;
    end else if (load) begin
      state    <= START;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= fifo_dout;
      cfg_wls  <= wls;
      cfg_stb  <= stb;
      cfg_pen  <= pen;
      cfg_par  <= par_bit;
      line     <= 1'b0;
    end else if (baud_pulse) begin
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          line     <= 1'b1;
        end
        START: begin
          if (tick_cnt == BIT_LAST) begin
            state    <= DATA;
            tick_cnt <= '0;
            line     <= shift[0];
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt <= '0;
            if (bit_cnt == data_last) begin
              if (cfg_pen) begin
                state <= PARITY;
                line  <= cfg_par;
              end else begin
                state <= STOP;
                line  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              line    <= shift[1];
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (tick_cnt == BIT_LAST) begin
            state    <= STOP;
            tick_cnt <= '0;
            line     <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          // Final stop tick without a reload (reload handled above).
          if (tick_cnt == stop_last) begin
            state    <= IDLE;
            tick_cnt <= '0;
            line     <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          line     <= 1'b1;
        end
      endcase
    end
  end

  assign pop  = load;
  assign tx   = line & ~bc;   // break overrides the line, FSM keeps running
  assign busy = (state != IDLE);
  assign temt = (state == IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
//   Randomized bench with a frame-level reference model: each loaded byte is
//   expanded into its expected per-tick line waveform (start, data, parity,
//   stop) and the DUT line, busy, temt and pop are compared every clock.
//   The bench also plays the role of the TX FIFO.
module tb_uart_tx_serializer;

  localparam int OS  = 16;
  localparam int DIV = 4;      // clk cycles per baud_pulse

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_pulse = 1'b0;
  logic [1:0] wls = 2'b11;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sp  = 1'b0;
  logic       bc  = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       pop;
  logic       tx;
  logic       busy;
  logic       temt;

  uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_pulse (baud_pulse),
    .wls        (wls),
    .stb        (stb),
    .pen        (pen),
    .eps        (eps),
    .sp         (sp),
    .bc         (bc),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .pop        (pop),
    .tx         (tx),
    .busy       (busy),
    .temt       (temt)
  );

  typedef bit wave_t[$];

  int  compared   = 0;
  int  mismatched = 0;
  logic [7:0] q[$];          // FIFO contents
  wave_t wave;               // expected line, one entry per tick of the frame
  bit  m_active = 1'b0;
  int  m_pos    = 0;
  bit  m_line   = 1'b1;
  int  busy_samples = 0;
  int  pop_samples  = 0;
  int  div_cnt      = 0;
  bit  e_tx, e_busy, e_temt, e_pop;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame waveform from the protocol rules.
  function automatic wave_t build(input logic [7:0] d, input logic [1:0] w,
                                  input logic s, input logic p,
                                  input logic e, input logic st);
    wave_t r;
    int n = int'(w) + 5;
    int ones = 0;
    int stop_len;
    bit par;
    repeat (OS) r.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      ones += int'(d[i]);
      repeat (OS) r.push_back(d[i]);
    end
    if (p) begin
      par = st ? !e : (e ? bit'(ones % 2) : !bit'(ones % 2));
      repeat (OS) r.push_back(par);
    end
    stop_len = !s ? OS : ((w == 2'b00) ? (OS * 3) / 2 : 2 * OS);
    repeat (stop_len) r.push_back(1'b1);
    return r;
  endfunction

  // Baud tick generator.
  always @(posedge clk) begin
    #1;
    baud_pulse = (div_cnt == DIV - 1);
    div_cnt    = (div_cnt + 1) % DIV;
  end

  // FIFO flag/head outputs follow the queue.
  always @(posedge clk) begin
    #2;
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
  end

  // Reference model, advanced on the same edges the DUT sees.
  always @(posedge clk) begin
    bit done;
    if (!rst) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_line   = 1'b1;
    end else if (baud_pulse) begin
      done = !m_active;
      if (m_active) begin
        m_pos++;
        if (m_pos == wave.size()) done = 1'b1;
      end
      if (done) begin
        if (!fifo_empty) begin
          wave     = build(fifo_dout, wls, stb, pen, eps, sp);
          void'(q.pop_front());
          m_active = 1'b1;
          m_pos    = 0;
          m_line   = wave[0];
        end else begin
          m_active = 1'b0;
          m_line   = 1'b1;
        end
      end else begin
        m_line = wave[m_pos];
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    e_busy = rst && m_active;
    e_tx   = bc ? 1'b0 : (rst ? m_line : 1'b1);
    e_temt = !e_busy && fifo_empty;
    e_pop  = rst && baud_pulse && !fifo_empty &&
             (!m_active || (m_pos + 1 == wave.size()));
    chk("tx",   int'(tx),   int'(e_tx));
    chk("busy", int'(busy), int'(e_busy));
    chk("temt", int'(temt), int'(e_temt));
    chk("pop",  int'(pop),  int'(e_pop));
    if (busy) busy_samples++;
    if (pop)  pop_samples++;
  end

  task automatic drive_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic s, input logic p,
                         input logic e, input logic st);
    wls = w; stb = s; pen = p; eps = e; sp = st;
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #1;
    q.push_back(b);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_active || q.size() != 0) && n < 8000);
    if (n >= 8000) chk({nm, "_idle_timeout"}, 0, 1);
    drive_cycles(2);
  endtask

  task automatic wait_active(input string nm);
    int n = 0;
    while (!m_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({nm, "_start_timeout"}, 0, 1);
  endtask

  // Run one directed frame group and check its busy duration and pop count.
  task automatic directed(input string nm, input logic [7:0] b0, input int nbytes,
                          input logic [7:0] b1, input int busy_clk);
    int bs0 = busy_samples;
    int ps0 = pop_samples;
    @(posedge clk);
    #1;
    q.push_back(b0);
    if (nbytes > 1) q.push_back(b1);
    wait_idle(nm);
    chk({nm, "_busy_clk"}, busy_samples - bs0, busy_clk);
    chk({nm, "_pops"}, pop_samples - ps0, nbytes);
  endtask

  initial begin
    wave_t w;
    // Pin the model with hand-computed frames.
    w = build(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("model_8n1_len", w.size(), 160);
    chk("model_8n1_b0", int'(w[16]), 1);
    chk("model_8n1_b1", int'(w[32]), 0);
    w = build(8'h41, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("model_7e1_len", w.size(), 160);
    chk("model_7e1_par", int'(w[128]), 0);
    w = build(8'h41, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("model_7o1_par", int'(w[128]), 1);
    w = build(8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("model_5n15_len", w.size(), 120);
    w = build(8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("model_stick0_par", int'(w[144]), 1);
    w = build(8'h00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("model_stick1_par", int'(w[144]), 0);

    // Reset state.
    drive_cycles(5);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_temt", int'(temt), 1);
    rst = 1'b1;
    drive_cycles(10);

    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("t1_55", 8'h55, 1, 8'h00, 640);
    set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    directed("t2_41_even", 8'h41, 1, 8'h00, 640);
    set_cfg(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    directed("t2_41_odd", 8'h41, 1, 8'h00, 640);
    set_cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    directed("t3_1f", 8'h1F, 1, 8'h00, 480);
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("t4_b2b", 8'hA5, 2, 8'h3C, 1280);
    set_cfg(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    directed("t5_stick_e0", 8'h00, 1, 8'h00, 704);
    set_cfg(2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    directed("t5_stick_e1", 8'h00, 1, 8'h00, 704);

    // Break in the middle of a 0xFF frame.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'hFF);
    wait_active("t6_bc");
    drive_cycles(40 * DIV);
    bc = 1'b1;
    @(negedge clk);
    chk("t6_bc_tx_low", int'(tx), 0);
    drive_cycles(60 * DIV);
    bc = 1'b0;
    @(negedge clk);
    chk("t6_bc_release_tx", int'(tx), 1);
    wait_idle("t6_bc");

    // Reset mid-frame with bytes still waiting.
    push(8'h5A);
    push(8'h77);
    wait_active("t6_rst");
    drive_cycles(50 * DIV);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_tx", int'(tx), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_pop", int'(pop), 0);
    drive_cycles(20);
    rst = 1'b1;
    wait_idle("t6_rst");

    // Randomized frames, mid-frame config changes and break windows.
    for (int it = 0; it < 20; it++) begin
      set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      q.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) q.push_back(8'($urandom));
      drive_cycles($urandom_range(1, 200));
      set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        bc = 1'b1;
        drive_cycles($urandom_range(1, 60));
        bc = 1'b0;
      end
      wait_idle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
